// File: rtl/sevenseg_capture_if.sv
// Bundle of the four sampled digit buses and the published-frame handshake.
// sq_ok exists only when SEVENSEG_SQUARE_CHECK_EN is defined.
interface sevenseg_capture_if;
  logic [6:0] ss1_0;
  logic [6:0] ss1_1;
  logic [6:0] ss2_0;
  logic [6:0] ss2_1;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] val1;
  logic [7:0] val2;
  logic [3:0] digit_err;
  logic [3:0] blank;
  logic       overrun;
`ifdef SEVENSEG_SQUARE_CHECK_EN
  logic       sq_ok;

  // master drives the display lines and consumes frames; slave is the capture block
  modport master (
    output ss1_0, ss1_1, ss2_0, ss2_1, out_ready,
    input  out_valid, val1, val2, digit_err, blank, overrun, sq_ok
  );

  modport slave (
    input  ss1_0, ss1_1, ss2_0, ss2_1, out_ready,
    output out_valid, val1, val2, digit_err, blank, overrun, sq_ok
  );
`else
  modport master (
    output ss1_0, ss1_1, ss2_0, ss2_1, out_ready,
    input  out_valid, val1, val2, digit_err, blank, overrun
  );

  modport slave (
    input  ss1_0, ss1_1, ss2_0, ss2_1, out_ready,
    output out_valid, val1, val2, digit_err, blank, overrun
  );
`endif
endinterface

// File: rtl/sevenseg_capture.sv
// Samples four 7-segment digit buses, waits for them to settle, decodes them back to
// two hex bytes and publishes each new frame once. Optional SEVENSEG_SQUARE_CHECK_EN adds sq_ok.
module sevenseg_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input logic               clk,
  input logic               rst,
  sevenseg_capture_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [7:0] CNT_SAT    = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_STABLE = 8'(STABLE_CYCLES - 1);

  // Returns {illegal, blank, nibble}; blank and illegal patterns decode to nibble 0
  function automatic logic [5:0] decode_seg(input logic [6:0] p);
    logic [5:0] r;
    r = 6'b10_0000;
    case (p)
      7'h3F:   r = {2'b00, 4'h0};
      7'h06:   r = {2'b00, 4'h1};
      7'h5B:   r = {2'b00, 4'h2};
      7'h4F:   r = {2'b00, 4'h3};
      7'h66:   r = {2'b00, 4'h4};
      7'h6D:   r = {2'b00, 4'h5};
      7'h7D:   r = {2'b00, 4'h6};
      7'h07:   r = {2'b00, 4'h7};
      7'h7F:   r = {2'b00, 4'h8};
      7'h6F:   r = {2'b00, 4'h9};
      7'h77:   r = {2'b00, 4'hA};
      7'h7C:   r = {2'b00, 4'hB};
      7'h39:   r = {2'b00, 4'hC};
      7'h5E:   r = {2'b00, 4'hD};
      7'h79:   r = {2'b00, 4'hE};
      7'h71:   r = {2'b00, 4'hF};
      7'h00:   r = 6'b01_0000;
      default: r = 6'b10_0000;
    endcase
    return r;
  endfunction

  logic [27:0] s_in;
  logic [27:0] s_q;
  logic [27:0] s_prev;
  logic [27:0] last_word;
  logic [7:0]  cnt;
  logic        have_pub;
  state_t      state;

  logic [5:0]  d10, d11, d20, d21;
  logic [7:0]  next_val1;
  logic [7:0]  next_val2;
  logic [3:0]  next_err;
  logic [3:0]  next_blank;
  logic        stable;
  logic        publish;

  logic        out_valid_q;
  logic [7:0]  val1_q;
  logic [7:0]  val2_q;
  logic [3:0]  digit_err_q;
  logic [3:0]  blank_q;
  logic        overrun_q;

  assign s_in = SEG_ACTIVE_LOW ? ~{bus.ss2_1, bus.ss2_0, bus.ss1_1, bus.ss1_0}
                               :  {bus.ss2_1, bus.ss2_0, bus.ss1_1, bus.ss1_0};

  assign d10 = decode_seg(s_q[6:0]);
  assign d11 = decode_seg(s_q[13:7]);
  assign d20 = decode_seg(s_q[20:14]);
  assign d21 = decode_seg(s_q[27:21]);

  assign next_val1  = {d11[3:0], d10[3:0]};
  assign next_val2  = {d21[3:0], d20[3:0]};
  assign next_err   = {d21[5], d20[5], d11[5], d10[5]};
  assign next_blank = {d21[4], d20[4], d11[4], d10[4]};

  // The counter saturates, so a held word is "stable" for exactly one cycle
  assign stable  = (s_q == s_prev) && (cnt == CNT_STABLE);
  assign publish = stable && (!have_pub || (s_q != last_word));

`ifdef SEVENSEG_SQUARE_CHECK_EN
  logic [15:0] square;
  logic        next_sq_ok;
  logic        sq_ok_q;

  assign square     = {8'd0, next_val1} * {8'd0, next_val1};
  assign next_sq_ok = (next_err == 4'd0) && (next_val2 == square[7:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sq_ok_q <= 1'b0;
    end else if (publish) begin
      sq_ok_q <= next_sq_ok;
    end
  end

  assign bus.sq_ok = sq_ok_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      s_prev      <= '0;
      last_word   <= '0;
      cnt         <= '0;
      have_pub    <= 1'b0;
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      val1_q      <= '0;
      val2_q      <= '0;
      digit_err_q <= '0;
      blank_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      s_q    <= s_in;
      s_prev <= s_q;

      if (s_q != s_prev) begin
        cnt <= '0;
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + 8'd1;
      end

      overrun_q <= 1'b0;

      if (publish) begin
        val1_q      <= next_val1;
        val2_q      <= next_val2;
        digit_err_q <= next_err;
        blank_q     <= next_blank;
        last_word   <= s_q;
        have_pub    <= 1'b1;
      end

      // A publish into FULL without ready replaces an unread frame
      case (state)
        EMPTY: begin
          if (publish) begin
            state       <= FULL;
            out_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (publish) begin
            overrun_q <= ~bus.out_ready;
          end else if (bus.out_ready) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.val1      = val1_q;
  assign bus.val2      = val2_q;
  assign bus.digit_err = digit_err_q;
  assign bus.blank     = blank_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Scoreboard bench for sevenseg_capture: directed frames push expectations, a monitor
// pops them whenever a new frame appears. sq_ok is checked when SEVENSEG_SQUARE_CHECK_EN is defined.
module tb_sevenseg_capture;

  typedef struct {
    logic [7:0] v1;
    logic [7:0] v2;
    logic [3:0] err;
    logic [3:0] blank;
    logic       ovr;
    logic       sq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  sevenseg_capture_if bus();

  sevenseg_capture #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    return p;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_raw(input logic [6:0] p11, input logic [6:0] p10,
                           input logic [6:0] p21, input logic [6:0] p20);
    bus.ss1_1 = p11;
    bus.ss1_0 = p10;
    bus.ss2_1 = p21;
    bus.ss2_0 = p20;
  endtask

  task automatic apply_stimulus(input logic [7:0] v1, input logic [7:0] v2);
    apply_raw(seg_of(v1[7:4]), seg_of(v1[3:0]), seg_of(v2[7:4]), seg_of(v2[3:0]));
  endtask

  task automatic push_expect(input logic [7:0] v1, input logic [7:0] v2,
                             input logic [3:0] err, input logic [3:0] blank, input logic ovr);
    exp_t e;
    logic [15:0] sq16;
    sq16    = 16'(v1) * 16'(v1);
    e.v1    = v1;
    e.v2    = v2;
    e.err   = err;
    e.blank = blank;
    e.ovr   = ovr;
    e.sq    = (err == 4'd0) && (v2 == sq16[7:0]);
    exp_q.push_back(e);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    check_output("valid_drop_after_accept", 32'(bus.out_valid), 32'd0);
  endtask

  // Monitor: a new frame is a rise of out_valid or a change of the held values
  initial begin : monitor
    logic        prev_valid;
    logic [23:0] prev_snap;
    logic [23:0] snap;
    exp_t        e;
    prev_valid = 1'b0;
    prev_snap  = '0;
    forever begin
      @(negedge clk);
      snap = {bus.val1, bus.val2, bus.digit_err, bus.blank};
      if (bus.out_valid === 1'b1 && (!prev_valid || snap != prev_snap)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_publish: got val1=0x%0h val2=0x%0h, expected no frame",
                   bus.val1, bus.val2);
        end else begin
          e = exp_q.pop_front();
          check_output("val1", 32'(bus.val1), 32'(e.v1));
          check_output("val2", 32'(bus.val2), 32'(e.v2));
          check_output("digit_err", 32'(bus.digit_err), 32'(e.err));
          check_output("blank", 32'(bus.blank), 32'(e.blank));
          check_output("overrun", 32'(bus.overrun), 32'(e.ovr));
`ifdef SEVENSEG_SQUARE_CHECK_EN
          check_output("sq_ok", 32'(bus.sq_ok), 32'(e.sq));
`endif
        end
      end else if (bus.overrun === 1'b1) begin
        checks++;
        errors++;
        $display("[TB] FAIL stray_overrun: got 1, expected 0");
      end
      prev_valid = (bus.out_valid === 1'b1);
      prev_snap  = snap;
    end
  end

  initial begin : stimulus
    int highs;
    bus.out_ready = 1'b0;
    apply_stimulus(8'h12, 8'h74);
    push_expect(8'h12, 8'h74, 4'h0, 4'h0, 1'b0);

    tick(2);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_val1", 32'(bus.val1), 32'd0);
    check_output("rst_val2", 32'(bus.val2), 32'd0);
    check_output("rst_digit_err", 32'(bus.digit_err), 32'd0);
    check_output("rst_blank", 32'(bus.blank), 32'd0);
    check_output("rst_overrun", 32'(bus.overrun), 32'd0);

    // First frame: out_valid rises on the fifth edge after the first sample edge
    rst = 1'b0;
    tick(5);
    check_output("latency_early", 32'(bus.out_valid), 32'd0);
    tick(1);
    check_output("latency_on_time", 32'(bus.out_valid), 32'd1);

    // Accept once, then the unchanged inputs must not republish
    consume();
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.out_valid) highs++;
    end
    check_output("dedupe_no_repub", 32'(highs), 32'd0);

    // A digit changing every two cycles never settles
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      bus.ss1_0 = (i % 2 == 1) ? 7'h06 : 7'h3F;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        if (bus.out_valid) highs++;
      end
    end
    check_output("toggle_no_publish", 32'(highs), 32'd0);
    push_expect(8'h11, 8'h74, 4'h0, 4'h0, 1'b0);
    tick(6);
    consume();

    // Overwrite of an unread frame
    apply_stimulus(8'h34, 8'h56);
    push_expect(8'h34, 8'h56, 4'h0, 4'h0, 1'b0);
    tick(6);
    apply_stimulus(8'h78, 8'h9A);
    push_expect(8'h78, 8'h9A, 4'h0, 4'h0, 1'b1);
    tick(7);
    check_output("overrun_one_cycle", 32'(bus.overrun), 32'd0);
    check_output("valid_held_after_overrun", 32'(bus.out_valid), 32'd1);
    check_output("val1_shows_b", 32'(bus.val1), 32'h78);

    // Ready coincides with the publish edge: old frame consumed, no overrun
    apply_stimulus(8'hAB, 8'hCD);
    push_expect(8'hAB, 8'hCD, 4'h0, 4'h0, 1'b0);
    tick(5);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    check_output("valid_after_ready_publish", 32'(bus.out_valid), 32'd1);
    consume();

    // Illegal and blank digits on display 2
    apply_raw(7'h3F, 7'h3F, 7'h55, 7'h00);
    push_expect(8'h00, 8'h00, 4'b1000, 4'b0100, 1'b0);
    tick(6);
    consume();

    apply_stimulus(8'h0C, 8'h90);
    push_expect(8'h0C, 8'h90, 4'h0, 4'h0, 1'b0);
    tick(6);
    consume();
    apply_stimulus(8'h11, 8'h20);
    push_expect(8'h11, 8'h20, 4'h0, 4'h0, 1'b0);
    tick(6);

    // Reset mid-settle while a frame is still pending
    apply_stimulus(8'h0C, 8'h90);
    tick(2);
    rst = 1'b1;
    tick(1);
    check_output("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("midrst_val1", 32'(bus.val1), 32'd0);
    check_output("midrst_val2", 32'(bus.val2), 32'd0);
    check_output("midrst_overrun", 32'(bus.overrun), 32'd0);
`ifdef SEVENSEG_SQUARE_CHECK_EN
    check_output("midrst_sq_ok", 32'(bus.sq_ok), 32'd0);
`endif
    rst = 1'b0;
    push_expect(8'h0C, 8'h90, 4'h0, 4'h0, 1'b0);
    tick(6);
    check_output("publish_after_reset", 32'(bus.out_valid), 32'd1);

    // Reset while FULL; the identical frame must publish again
    rst = 1'b1;
    tick(1);
    check_output("fullrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("fullrst_val2", 32'(bus.val2), 32'd0);
    rst = 1'b0;
    push_expect(8'h0C, 8'h90, 4'h0, 4'h0, 1'b0);
    tick(6);
    check_output("republish_same_frame", 32'(bus.out_valid), 32'd1);

    tick(2);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Receive-side counterpart of the square display driver. It samples the four 7-segment digit buses (two 2-digit displays) and waits until the display has settled.
- It then decodes each pattern back to a hex nibble, flags illegal patterns, and publishes the two 8-bit values through a valid/ready handshake.
- Used as an on-chip self-check monitor, or on a second board reading the display lines.

Parameters:
- STABLE_CYCLES, 4, consecutive clock edges the sampled 28-bit word must stay unchanged before it is published; legal range 1..255.
- SEG_ACTIVE_LOW, 0, 1 = segment inputs are active-low and are inverted at the input register.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- ss1_0  input  7  display 1 low digit, bit order {g,f,e,d,c,b,a}
- ss1_1  input  7  display 1 high digit
- ss2_0  input  7  display 2 low digit
- ss2_1  input  7  display 2 high digit
- out_ready  input  1  consumer accepts the frame when out_valid is high
- out_valid  output  1  a published frame is pending
- val1  output  8  {nibble(ss1_1), nibble(ss1_0)}
- val2  output  8  {nibble(ss2_1), nibble(ss2_0)}
- digit_err  output  4  per-digit illegal-pattern flag {ss2_1, ss2_0, ss1_1, ss1_0}
- blank  output  4  per-digit all-segments-off flag, same bit order
- overrun  output  1  one-cycle pulse: a pending frame was overwritten

Behaviour:
- Reset values: out_valid=0, val1=0, val2=0, digit_err=0, blank=0, overrun=0. Reset also clears the input register, the stability counter and the last-published record.
- Input register:
  - All 28 bits are registered every cycle into s_q, inverted first if SEG_ACTIVE_LOW=1.
  - s_prev holds the previous s_q.
- Stability counter cnt, 8 bits:
  - If s_q != s_prev, cnt <= 0.
  - Else cnt increments, saturating at STABLE_CYCLES.
  - "Stable" is the single cycle in which cnt == STABLE_CYCLES-1 and s_q == s_prev.
- Latency: inputs changed before edge E0 and then held produce out_valid=1 after edge E0+STABLE_CYCLES+1.
- Decode table, pattern -> nibble:
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9
  - 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F
  - 00 -> nibble 0 with blank=1
  - Any other pattern -> nibble 0 with digit_err=1
- Publish rule:
  - On the stable cycle, the frame is published if no frame has been published since reset, or if s_q differs from the last-published word.
  - Publishing loads val1, val2, digit_err and blank, sets out_valid=1, and records s_q as the last-published word.
  - An identical re-settle is not published again.
- Handshake FSM, states EMPTY and FULL:
  - EMPTY -> FULL on publish.
  - FULL -> EMPTY when out_ready=1 and there is no publish in the same cycle.
  - FULL with publish and out_ready=1: the old frame is consumed, the new frame is loaded, the FSM stays FULL, no overrun.
  - FULL with publish and out_ready=0: the new frame overwrites the old one and overrun pulses for 1 cycle.
- Output registers hold their values while in FULL. Outputs stay unchanged after the frame is consumed.
- Reset asserted mid-settle or while FULL: everything returns to reset values on the next edge. The next stable frame is published even if it is identical to the pre-reset frame.

Optional Feature:
- Macro SEVENSEG_SQUARE_CHECK_EN.
- When defined:
  - Adds output port sq_ok (1 bit, reset 0).
  - sq_ok is registered together with val1/val2 at publish.
  - sq_ok = 1 iff digit_err==0 and val2 == (val1*val1)[7:0].
  - The multiply is an 8x8 unsigned multiply; the upper 8 bits are discarded.
- When not defined: no port and no multiplier logic. All other behaviour is identical.

Test Plan:
- Reset, then hold ss1=06/5B, ss2=07/66 (val1 0x12, val2 0x74), STABLE_CYCLES=4, out_ready=0. Required: out_valid rises exactly 5 edges after the first sample edge; val1=0x12, val2=0x74, digit_err=0, blank=0.
- Toggle ss1_0 between 3F and 06 every 2 cycles for 20 cycles, STABLE_CYCLES=4. Required: no publish; out_valid stays 0.
- Hold a published frame, pulse out_ready for 1 cycle, then keep the inputs unchanged for 50 cycles. Required: out_valid drops after the accept and never reasserts (dedupe).
- Publish frame A with out_ready=0, then settle different frame B. Required: val outputs show B, overrun=1 for exactly 1 cycle, out_valid stays 1. Repeat with out_ready=1 on B's publish cycle. Required: overrun=0.
- Drive ss2_1=0x55 and ss2_0=0x00. Required: digit_err=4'b1000, blank=4'b0100, val2=0x00.
- With SEVENSEG_SQUARE_CHECK_EN, publish val1=0x0C, val2=0x90. Required: sq_ok=1. Publish val1=0x11, val2=0x20 (0x11*0x11=0x121, low byte 0x21). Required: sq_ok=0. Assert rst mid-settle. Required: all outputs 0 next edge, and the same frame republishes afterwards.
